string_char_serializer: RTL and testbench

Upstream feeder for per-character consumers such as the string display stage. It accepts a packed ASCII string register, the same layout as a Verilog string literal with the leftmost character in the MSBs. It then streams the string out one character per cycle on a valid/ready interface, in left-to-right order. It can optionally drop the leading NUL padding that a Verilog string assignment leaves when the register is wider than the literal.

---
 rtl/string_stream_pkg.sv | 18 +
 rtl/string_shift_reg.sv | 53 +++++
 rtl/string_char_serializer.sv | 130 +++++++++++++
 tb/tb_string_char_serializer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/string_stream_pkg.sv
// Shared definitions for the string streaming blocks: FSM encoding,
// the NUL character value and the default character width.
package string_stream_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SKIP   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  localparam logic [7:0] CHAR_NUL       = 8'h00;
  localparam int         DEFAULT_CHAR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_SKIP   = S_SKIP,
    ST_STREAM = S_STREAM
  } state_e;

endpackage

// File: rtl/string_shift_reg.sv
// Parallel-load string register that shifts left one character at a time.
// Exposes the leftmost (top) character and the one right behind it so the
// controller can look one character ahead while dropping leading NULs.
module string_shift_reg #(
  parameter int NCHARS = 11,
  parameter int CHAR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en_i,
  input  logic                     shift_en_i,
  input  logic [NCHARS*CHAR_W-1:0] load_data_i,
  output logic [CHAR_W-1:0]        top_char_o,
  output logic [CHAR_W-1:0]        next_char_o
);

  localparam int SR_W = NCHARS * CHAR_W;

  logic [SR_W-1:0] sr_q;
  logic [SR_W-1:0] sr_d;

  // Next contents: a load wins over a shift; zeros enter from the right.
  always_comb begin
    sr_d = sr_q;
    if (load_en_i) begin
      sr_d = load_data_i;
    end else if (shift_en_i) begin
      sr_d = sr_q << CHAR_W;
    end else begin
      sr_d = sr_q;
    end
  end

  // String storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign top_char_o = sr_q[SR_W-1 -: CHAR_W];

  generate
    if (NCHARS > 1) begin : g_next
      assign next_char_o = sr_q[SR_W-CHAR_W-1 -: CHAR_W];
    end else begin : g_no_next
      assign next_char_o = '0;
    end
  endgenerate

endmodule

// File: rtl/string_char_serializer.sv
// Streams a packed ASCII string one character per cycle, leftmost first,
// optionally dropping the leading NUL padding of a wide string register.
module string_char_serializer
  import string_stream_pkg::*;
#(
  parameter int NCHARS = 11,
  parameter int CHAR_W = DEFAULT_CHAR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [NCHARS*CHAR_W-1:0]     load_str,
  input  logic                         skip_nul,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHAR_W-1:0]            out_char,
  output logic [$clog2(NCHARS+1)-1:0]  out_index,
  output logic                         out_last,
  output logic                         busy
);

  localparam int                CNT_W    = $clog2(NCHARS + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NCHARS);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CHAR_W-1:0] NUL      = CHAR_W'(CHAR_NUL);

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              load_en_s;
  logic              shift_en_s;
  logic [CHAR_W-1:0] top_char_s;
  logic [CHAR_W-1:0] next_char_s;
  logic [CHAR_W-1:0] load_top_s;

  assign load_top_s = load_str[NCHARS*CHAR_W-1 -: CHAR_W];

  string_shift_reg #(
    .NCHARS (NCHARS),
    .CHAR_W (CHAR_W)
  ) u_sr (
    .clk         (clk),
    .rst         (rst),
    .load_en_i   (load_en_s),
    .shift_en_i  (shift_en_s),
    .load_data_i (load_str),
    .top_char_o  (top_char_s),
    .next_char_o (next_char_s)
  );

  // Next-state, counter and shift control. SKIP is entered only when the
  // string really starts with NUL, and it leaves as soon as the character
  // being shifted in is non-NUL, so the first character appears one cycle
  // per leading NUL after the load.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_en_s  = 1'b0;
    shift_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          load_en_s = 1'b1;
          cnt_d     = CNT_FULL;
          if (skip_nul && (load_top_s == NUL)) begin
            state_d = ST_SKIP;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SKIP: begin
        if (top_char_s == NUL) begin
          shift_en_s = 1'b1;
          cnt_d      = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
          end else if (next_char_s != NUL) begin
            state_d = ST_STREAM;
          end else begin
            state_d = ST_SKIP;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          shift_en_s = 1'b1;
          cnt_d      = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and remaining-character counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode only from registered state; nothing depends on out_ready
  // or load_valid combinationally.
  assign out_valid  = (state_q == ST_STREAM);
  assign out_char   = out_valid ? top_char_s : '0;
  assign out_index  = out_valid ? (CNT_FULL - cnt_q) : '0;
  assign out_last   = out_valid && (cnt_q == CNT_ONE);
  assign busy       = (state_q != ST_IDLE);
  assign load_ready = (state_q == ST_IDLE) && !rst;

endmodule

// File: tb/tb_string_char_serializer.sv
// Directed bench for string_char_serializer using three instances with
// 11-, 4- and 2-character capacity.
module tb_string_char_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: NCHARS = 11
  logic        a_rst, a_load_valid, a_load_ready, a_skip_nul;
  logic        a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [87:0] a_load_str;
  logic [7:0]  a_out_char;
  logic [3:0]  a_out_index;

  // Instance B: NCHARS = 4
  logic        b_rst, b_load_valid, b_load_ready, b_skip_nul;
  logic        b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [31:0] b_load_str;
  logic [7:0]  b_out_char;
  logic [2:0]  b_out_index;

  // Instance C: NCHARS = 2
  logic        c_rst, c_load_valid, c_load_ready, c_skip_nul;
  logic        c_out_valid, c_out_ready, c_out_last, c_busy;
  logic [15:0] c_load_str;
  logic [7:0]  c_out_char;
  logic [1:0]  c_out_index;

  string_char_serializer #(.NCHARS(11), .CHAR_W(8)) u_a (
    .clk(clk), .rst(a_rst), .load_valid(a_load_valid), .load_ready(a_load_ready),
    .load_str(a_load_str), .skip_nul(a_skip_nul), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_char(a_out_char), .out_index(a_out_index),
    .out_last(a_out_last), .busy(a_busy)
  );

  string_char_serializer #(.NCHARS(4), .CHAR_W(8)) u_b (
    .clk(clk), .rst(b_rst), .load_valid(b_load_valid), .load_ready(b_load_ready),
    .load_str(b_load_str), .skip_nul(b_skip_nul), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_char(b_out_char), .out_index(b_out_index),
    .out_last(b_out_last), .busy(b_busy)
  );

  string_char_serializer #(.NCHARS(2), .CHAR_W(8)) u_c (
    .clk(clk), .rst(c_rst), .load_valid(c_load_valid), .load_ready(c_load_ready),
    .load_str(c_load_str), .skip_nul(c_skip_nul), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_char(c_out_char), .out_index(c_out_index),
    .out_last(c_out_last), .busy(c_busy)
  );

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    tick();
    tick();
    checks++; if (a_load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready_a: got %b want 0", a_load_ready); end
    checks++; if (b_load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready_b: got %b want 0", b_load_ready); end
    checks++; if (c_load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready_c: got %b want 0", c_load_ready); end
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_out_last !== 1'b0) begin
      errors++; $display("FAIL reset_flags_a: valid=%b busy=%b last=%b want 0 0 0", a_out_valid, a_busy, a_out_last);
    end
    checks++; if (a_out_char !== 8'h00 || a_out_index !== 4'd0) begin
      errors++; $display("FAIL reset_data_a: char=%h index=%0d want 00 0", a_out_char, a_out_index);
    end
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    tick();
    checks++; if (a_load_ready !== 1'b1 || b_load_ready !== 1'b1 || c_load_ready !== 1'b1) begin
      errors++; $display("FAIL idle_load_ready: got %b%b%b want 111", a_load_ready, b_load_ready, c_load_ready);
    end
  endtask

  task automatic test_hello;
    logic [7:0] exp [11];
    exp = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57, 8'h6f, 8'h72, 8'h6c, 8'h64};
    a_load_str = "Hello World"; a_skip_nul = 1'b0; a_out_ready = 1'b1; a_load_valid = 1'b1;
    tick();
    a_load_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL hello_valid[%0d]: got %b want 1", i, a_out_valid); end
      checks++; if (a_out_char !== exp[i]) begin errors++; $display("FAIL hello_char[%0d]: got %h want %h", i, a_out_char, exp[i]); end
      checks++; if (a_out_index !== 4'(i)) begin errors++; $display("FAIL hello_index[%0d]: got %0d want %0d", i, a_out_index, i); end
      checks++; if (a_out_last !== (i == 10)) begin errors++; $display("FAIL hello_last[%0d]: got %b want %b", i, a_out_last, (i == 10)); end
      tick();
    end
    checks++; if (a_out_valid !== 1'b0 || a_load_ready !== 1'b1) begin
      errors++; $display("FAIL hello_done: valid=%b load_ready=%b want 0 1", a_out_valid, a_load_ready);
    end
  endtask

  task automatic test_skip_one;
    b_load_str = 32'h00000031; b_skip_nul = 1'b1; b_out_ready = 1'b1; b_load_valid = 1'b1;
    tick();
    b_load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b1) begin
        errors++; $display("FAIL skip1_quiet[%0d]: valid=%b busy=%b want 0 1", i, b_out_valid, b_busy);
      end
      tick();
    end
    checks++; if (b_out_valid !== 1'b1 || b_out_char !== 8'h31) begin
      errors++; $display("FAIL skip1_char: valid=%b char=%h want 1 31", b_out_valid, b_out_char);
    end
    checks++; if (b_out_index !== 3'd3 || b_out_last !== 1'b1) begin
      errors++; $display("FAIL skip1_pos: index=%0d last=%b want 3 1", b_out_index, b_out_last);
    end
    tick();
    checks++; if (b_out_valid !== 1'b0 || b_load_ready !== 1'b1) begin
      errors++; $display("FAIL skip1_done: valid=%b load_ready=%b want 0 1", b_out_valid, b_load_ready);
    end
  endtask

  task automatic test_all_nul;
    b_load_str = 32'h00000000; b_skip_nul = 1'b1; b_out_ready = 1'b1; b_load_valid = 1'b1;
    tick();
    b_load_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (b_out_valid !== 1'b0 || b_load_ready !== 1'b0) begin
        errors++; $display("FAIL allnul_cycle[%0d]: valid=%b load_ready=%b want 0 0", i, b_out_valid, b_load_ready);
      end
      tick();
    end
    checks++; if (b_load_ready !== 1'b1 || b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL allnul_return: load_ready=%b valid=%b busy=%b want 1 0 0", b_load_ready, b_out_valid, b_busy);
    end
  endtask

  task automatic test_backpressure;
    c_load_str = 16'h3232; c_skip_nul = 1'b0; c_out_ready = 1'b1; c_load_valid = 1'b1;
    tick();
    c_load_valid = 1'b0;
    checks++; if (c_out_valid !== 1'b1 || c_out_char !== 8'h32 || c_out_index !== 2'd0 || c_out_last !== 1'b0) begin
      errors++; $display("FAIL bp_first: valid=%b char=%h index=%0d last=%b want 1 32 0 0", c_out_valid, c_out_char, c_out_index, c_out_last);
    end
    c_out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (c_out_valid !== 1'b1 || c_out_char !== 8'h32 || c_out_index !== 2'd1 || c_out_last !== 1'b1) begin
        errors++; $display("FAIL bp_second[%0d]: valid=%b char=%h index=%0d last=%b want 1 32 1 1", i, c_out_valid, c_out_char, c_out_index, c_out_last);
      end
      c_out_ready = (i == 2);
      tick();
    end
    checks++; if (c_load_ready !== 1'b1 || c_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_done: load_ready=%b valid=%b want 1 0", c_load_ready, c_out_valid);
    end
    c_out_ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    a_load_str = "Hello World"; a_skip_nul = 1'b0; a_out_ready = 1'b1; a_load_valid = 1'b1;
    tick();
    a_load_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (a_out_index !== 4'd3 || a_out_char !== 8'h6c) begin
      errors++; $display("FAIL rst_pre: index=%0d char=%h want 3 6c", a_out_index, a_out_char);
    end
    a_rst = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_out_char !== 8'h00 || a_busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid: valid=%b char=%h busy=%b want 0 00 0", a_out_valid, a_out_char, a_busy);
    end
    checks++; if (a_out_index !== 4'd0 || a_load_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idx: index=%0d load_ready=%b want 0 0", a_out_index, a_load_ready);
    end
    a_rst = 1'b0;
    tick();
    a_load_str = {72'h0, 16'h3232}; a_skip_nul = 1'b1; a_load_valid = 1'b1;
    tick();
    a_load_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_reload_quiet[%0d]: valid=%b want 0", i, a_out_valid); end
      tick();
    end
    checks++; if (a_out_valid !== 1'b1 || a_out_char !== 8'h32 || a_out_index !== 4'd9 || a_out_last !== 1'b0) begin
      errors++; $display("FAIL rst_reload_c0: valid=%b char=%h index=%0d last=%b want 1 32 9 0", a_out_valid, a_out_char, a_out_index, a_out_last);
    end
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_out_char !== 8'h32 || a_out_index !== 4'd10 || a_out_last !== 1'b1) begin
      errors++; $display("FAIL rst_reload_c1: valid=%b char=%h index=%0d last=%b want 1 32 10 1", a_out_valid, a_out_char, a_out_index, a_out_last);
    end
    tick();
    checks++; if (a_load_ready !== 1'b1) begin errors++; $display("FAIL rst_reload_done: load_ready=%b want 1", a_load_ready); end
  endtask

  task automatic test_back_to_back;
    c_load_str = 16'h4142; c_skip_nul = 1'b0; c_out_ready = 1'b1; c_load_valid = 1'b1;
    tick();
    c_load_str = 16'h5a5a;
    checks++; if (c_load_ready !== 1'b0 || c_busy !== 1'b1 || c_out_char !== 8'h41 || c_out_index !== 2'd0) begin
      errors++; $display("FAIL b2b_a: load_ready=%b busy=%b char=%h index=%0d want 0 1 41 0", c_load_ready, c_busy, c_out_char, c_out_index);
    end
    tick();
    checks++; if (c_load_ready !== 1'b0 || c_out_char !== 8'h42 || c_out_last !== 1'b1) begin
      errors++; $display("FAIL b2b_b: load_ready=%b char=%h last=%b want 0 42 1", c_load_ready, c_out_char, c_out_last);
    end
    tick();
    checks++; if (c_load_ready !== 1'b1 || c_out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_bubble: load_ready=%b valid=%b want 1 0", c_load_ready, c_out_valid);
    end
    tick();
    c_load_valid = 1'b0;
    checks++; if (c_out_valid !== 1'b1 || c_out_char !== 8'h5a || c_out_index !== 2'd0) begin
      errors++; $display("FAIL b2b_z0: valid=%b char=%h index=%0d want 1 5a 0", c_out_valid, c_out_char, c_out_index);
    end
    tick();
    checks++; if (c_out_char !== 8'h5a || c_out_index !== 2'd1 || c_out_last !== 1'b1) begin
      errors++; $display("FAIL b2b_z1: char=%h index=%0d last=%b want 5a 1 1", c_out_char, c_out_index, c_out_last);
    end
    tick();
    checks++; if (c_load_ready !== 1'b1 || c_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_done: load_ready=%b busy=%b want 1 0", c_load_ready, c_busy);
    end
  endtask

  initial begin
    a_load_valid = 1'b0; a_load_str = '0; a_skip_nul = 1'b0; a_out_ready = 1'b0;
    b_load_valid = 1'b0; b_load_str = '0; b_skip_nul = 1'b0; b_out_ready = 1'b0;
    c_load_valid = 1'b0; c_load_str = '0; c_skip_nul = 1'b0; c_out_ready = 1'b0;
    test_reset();
    test_hello();
    test_skip_one();
    test_all_nul();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
